// File: rtl/wb_reg_writer_if.sv
// Result handshake between the MEM stage and the register-file write-back buffer.
// The master offers a completed result; the slave raises in_ready while it has room.
interface wb_reg_writer_if;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic [31:0] in_data;

    modport master (
        output in_valid,
        output in_rd,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_rd,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/wb_reg_writer.sv
// Register-file write-back buffer: an in-order FIFO of completed results drained
// one per cycle onto the write port, with forwarding of results not yet written.
module wb_reg_writer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    wb_reg_writer_if.slave   mem,
    input  logic             wr_stall,
    output logic             we,
    output logic [4:0]       reg_write,
    output logic [31:0]      data_write,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    output logic             fwd1_hit,
    output logic             fwd2_hit,
    output logic [31:0]      fwd1_data,
    output logic [31:0]      fwd2_data,
    output logic [PTR_W:0]   count
);

    localparam int RW = 5;
    localparam int DW = 32;
    localparam int CW = PTR_W + 1;

    typedef struct packed {
        logic [RW-1:0] rd;
        logic [DW-1:0] data;
    } entry_t;

    entry_t           slot_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic             push;
    logic             pop;

    // in_ready looks only at occupancy, so a full buffer refuses even while popping.
    assign mem.in_ready = (count != CW'(DEPTH));
    assign push         = mem.in_valid && mem.in_ready;
    assign pop          = (count != '0) && !wr_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count      <= '0;
            vld_q      <= '0;
            we         <= 1'b0;
            reg_write  <= '0;
            data_write <= '0;
        end else begin
            if (push) begin
                vld_q[tail_q] <= 1'b1;
                tail_q        <= tail_q + 1'b1;
            end
            if (pop) begin
                vld_q[head_q] <= 1'b0;
                head_q        <= head_q + 1'b1;
                we            <= (slot_q[head_q].rd != '0);
                reg_write     <= slot_q[head_q].rd;
                data_write    <= slot_q[head_q].data;
            end else begin
                we <= 1'b0;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Payload storage needs no reset; the valid bits and count guard it.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            slot_q[tail_q] <= '{rd: mem.in_rd, data: mem.in_data};
        end
    end

    // Scan oldest to youngest so the last match wins.
    function automatic logic [DW:0] lookup(input logic [RW-1:0] rs);
        logic [DW:0]      r;
        logic [PTR_W-1:0] idx;
        r = '0;
        if (we && reg_write == rs) begin
            r = {1'b1, data_write};
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if (CW'(i) < count && vld_q[idx] && slot_q[idx].rd == rs) begin
                r = {1'b1, slot_q[idx].data};
            end
        end
        if (rs == '0) begin
            r = '0;
        end
        return r;
    endfunction

    always_comb begin
        {fwd1_hit, fwd1_data} = lookup(rs1);
    end

    always_comb begin
        {fwd2_hit, fwd2_data} = lookup(rs2);
    end

endmodule

// File: tb/tb_wb_reg_writer.sv
// Bench for wb_reg_writer: fixed vector table, corner sequences and
// random traffic compared against a queue-based reference model.
module tb_wb_reg_writer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_stall;
    logic        we;
    logic [4:0]  reg_write;
    logic [31:0] data_write;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        fwd1_hit;
    logic        fwd2_hit;
    logic [31:0] fwd1_data;
    logic [31:0] fwd2_data;
    logic [2:0]  count;

    always #5 clk = ~clk;

    wb_reg_writer_if mem_if ();

    wb_reg_writer #(.DEPTH(4), .PTR_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem        (mem_if),
        .wr_stall   (wr_stall),
        .we         (we),
        .reg_write  (reg_write),
        .data_write (data_write),
        .rs1        (rs1),
        .rs2        (rs2),
        .fwd1_hit   (fwd1_hit),
        .fwd2_hit   (fwd2_hit),
        .fwd1_data  (fwd1_data),
        .fwd2_data  (fwd2_data),
        .count      (count)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        logic        v;
        logic [4:0]  rd;
        logic [31:0] d;
        logic        st;
        logic        r;
        logic [4:0]  s1;
        logic [4:0]  s2;
        logic        e_we;
        logic [4:0]  e_rw;
        logic [31:0] e_dw;
        logic [2:0]  e_cnt;
        logic        e_rdy;
        logic        e_h1;
        logic [31:0] e_d1;
        logic        e_h2;
        logic [31:0] e_d2;
    } vec_t;

    ent_t        q[$];
    logic        m_we;
    logic [4:0]  m_rw;
    logic [31:0] m_dw;
    int          tests = 0;
    int          fails = 0;
    vec_t        tbl[14];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: a plain queue of pending results plus the write-port register.
    task automatic model_step();
        ent_t e;
        bit   rdy;
        bit   pp;
        if (rst) begin
            q.delete();
            m_we = 1'b0;
            m_rw = '0;
            m_dw = '0;
        end else begin
            rdy = (q.size() < DEPTH);
            pp  = (q.size() != 0) && !wr_stall;
            if (pp) begin
                e    = q.pop_front();
                m_we = (e.rd != 0);
                m_rw = e.rd;
                m_dw = e.data;
            end else begin
                m_we = 1'b0;
            end
            if (mem_if.in_valid && rdy) begin
                e.rd   = mem_if.in_rd;
                e.data = mem_if.in_data;
                q.push_back(e);
            end
        end
    endtask

    function automatic void mfwd(input logic [4:0] rs, output logic h,
                                 output logic [31:0] d);
        h = 1'b0;
        d = '0;
        if (rs == 0) return;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].rd == rs) begin
                h = 1'b1;
                d = q[i].data;
                return;
            end
        end
        if (m_we && m_rw == rs) begin
            h = 1'b1;
            d = m_dw;
        end
    endfunction

    task automatic check_model(input string tag);
        logic        h1;
        logic        h2;
        logic [31:0] d1;
        logic [31:0] d2;
        mfwd(rs1, h1, d1);
        mfwd(rs2, h2, d2);
        chk({tag, ".we"}, we, m_we);
        chk({tag, ".reg_write"}, reg_write, m_rw);
        chk({tag, ".data_write"}, data_write, m_dw);
        chk({tag, ".count"}, count, q.size());
        chk({tag, ".in_ready"}, mem_if.in_ready, q.size() < DEPTH);
        chk({tag, ".fwd1_hit"}, fwd1_hit, h1);
        chk({tag, ".fwd1_data"}, fwd1_data, d1);
        chk({tag, ".fwd2_hit"}, fwd2_hit, h2);
        chk({tag, ".fwd2_data"}, fwd2_data, d2);
    endtask

    task automatic cyc(input logic v, input logic [4:0] rd,
                       input logic [31:0] d, input logic st, input logic r);
        mem_if.in_valid = v;
        mem_if.in_rd    = rd;
        mem_if.in_data  = d;
        wr_stall        = st;
        rst             = r;
        @(posedge clk);
        model_step();
        #1;
    endtask

    function automatic vec_t mk(int v, int rd, int d, int st, int r,
                                int s1, int s2, int ewe, int erw, int edw,
                                int ecnt, int erdy, int eh1, int ed1,
                                int eh2, int ed2);
        vec_t x;
        x.v     = v[0];
        x.rd    = rd[4:0];
        x.d     = d;
        x.st    = st[0];
        x.r     = r[0];
        x.s1    = s1[4:0];
        x.s2    = s2[4:0];
        x.e_we  = ewe[0];
        x.e_rw  = erw[4:0];
        x.e_dw  = edw;
        x.e_cnt = ecnt[2:0];
        x.e_rdy = erdy[0];
        x.e_h1  = eh1[0];
        x.e_d1  = ed1;
        x.e_h2  = eh2[0];
        x.e_d2  = ed2;
        return x;
    endfunction

    initial begin
        mem_if.in_valid = 1'b0;
        mem_if.in_rd    = '0;
        mem_if.in_data  = '0;
        wr_stall = 1'b0;
        rst      = 1'b1;
        rs1      = '0;
        rs2      = '0;

        //             v rd  d st r s1 s2 we rw  dw cnt rdy h1 d1 h2 d2
        tbl[0]  = mk(0, 0,  0, 0, 1, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0);
        tbl[1]  = mk(1, 1,  1, 0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 0, 0, 0);
        tbl[2]  = mk(0, 0,  0, 0, 0, 1, 0, 1, 1,  1, 0, 1, 1, 1, 0, 0);
        tbl[3]  = mk(0, 0,  0, 0, 0, 1, 0, 0, 1,  1, 0, 1, 0, 0, 0, 0);
        tbl[4]  = mk(1, 3, 30, 1, 0, 0, 0, 0, 1,  1, 1, 1, 0, 0, 0, 0);
        tbl[5]  = mk(1, 4, 40, 1, 0, 3, 0, 0, 1,  1, 2, 1, 1, 30, 0, 0);
        tbl[6]  = mk(1, 5, 50, 1, 0, 0, 0, 0, 1,  1, 3, 1, 0, 0, 0, 0);
        tbl[7]  = mk(1, 6, 60, 1, 0, 0, 0, 0, 1,  1, 4, 0, 0, 0, 0, 0);
        tbl[8]  = mk(0, 0,  0, 1, 0, 5, 0, 0, 1,  1, 4, 0, 1, 50, 0, 0);
        tbl[9]  = mk(0, 0,  0, 0, 0, 3, 4, 1, 3, 30, 3, 1, 1, 30, 1, 40);
        tbl[10] = mk(0, 0,  0, 0, 0, 6, 3, 1, 4, 40, 2, 1, 1, 60, 0, 0);
        tbl[11] = mk(0, 0,  0, 0, 0, 0, 0, 1, 5, 50, 1, 1, 0, 0, 0, 0);
        tbl[12] = mk(0, 0,  0, 0, 0, 0, 0, 1, 6, 60, 0, 1, 0, 0, 0, 0);
        tbl[13] = mk(0, 0,  0, 0, 0, 6, 0, 0, 6, 60, 0, 1, 0, 0, 0, 0);

        for (int i = 0; i < 14; i++) begin
            rs1 = tbl[i].s1;
            rs2 = tbl[i].s2;
            cyc(tbl[i].v, tbl[i].rd, tbl[i].d, tbl[i].st, tbl[i].r);
            chk($sformatf("tbl%0d.we", i), we, tbl[i].e_we);
            chk($sformatf("tbl%0d.reg_write", i), reg_write, tbl[i].e_rw);
            chk($sformatf("tbl%0d.data_write", i), data_write, tbl[i].e_dw);
            chk($sformatf("tbl%0d.count", i), count, tbl[i].e_cnt);
            chk($sformatf("tbl%0d.in_ready", i), mem_if.in_ready, tbl[i].e_rdy);
            chk($sformatf("tbl%0d.fwd1_hit", i), fwd1_hit, tbl[i].e_h1);
            chk($sformatf("tbl%0d.fwd1_data", i), fwd1_data, tbl[i].e_d1);
            chk($sformatf("tbl%0d.fwd2_hit", i), fwd2_hit, tbl[i].e_h2);
            chk($sformatf("tbl%0d.fwd2_data", i), fwd2_data, tbl[i].e_d2);
            check_model($sformatf("tbl%0d.model", i));
        end

        // Two pending writes to one register: the younger value forwards.
        cyc(0, 0, 0, 0, 1);
        rs1 = 5'd7;
        rs2 = 5'd8;
        cyc(1, 7, 5, 1, 0);
        cyc(1, 7, 9, 1, 0);
        chk("young.fwd1_hit", fwd1_hit, 1);
        chk("young.fwd1_data", fwd1_data, 9);
        chk("young.fwd2_hit", fwd2_hit, 0);
        chk("young.fwd2_data", fwd2_data, 0);
        check_model("young");

        // A result for x0 takes a slot but never asserts we.
        cyc(0, 0, 0, 0, 1);
        rs1 = 5'd0;
        rs2 = 5'd0;
        cyc(1, 0, 123, 0, 0);
        chk("rd0.count", count, 1);
        chk("rd0.fwd1_hit", fwd1_hit, 0);
        cyc(0, 0, 0, 0, 0);
        chk("rd0.we", we, 0);
        chk("rd0.count_after", count, 0);
        chk("rd0.fwd1_hit_after", fwd1_hit, 0);
        check_model("rd0");

        // Fill, then hold in_valid while draining across the pointer wrap.
        cyc(0, 0, 0, 0, 1);
        rs1 = 5'd2;
        rs2 = 5'd9;
        for (int i = 0; i < 4; i++) begin
            cyc(1, 5'(i + 1), 32'(100 + i), 1, 0);
            check_model("fill");
        end
        chk("full.in_ready", mem_if.in_ready, 0);
        cyc(1, 8, 200, 0, 0);
        chk("full.count_after_pop", count, 3);
        check_model("full.first");
        for (int i = 1; i < 10; i++) begin
            cyc(1, 5'(8 + i), 32'(200 + i), 0, 0);
            chk("full.count_le4", count <= 3'd4, 1);
            check_model("full.stream");
        end
        for (int i = 0; i < 6; i++) begin
            cyc(0, 0, 0, 0, 0);
            check_model("full.drain");
        end

        // Reset with three results buffered discards them all.
        cyc(0, 0, 0, 0, 1);
        cyc(1, 10, 1000, 1, 0);
        cyc(1, 11, 1100, 1, 0);
        cyc(1, 12, 1200, 1, 0);
        chk("mid.count_before", count, 3);
        rs1 = 5'd11;
        rs2 = 5'd12;
        cyc(0, 0, 0, 0, 1);
        chk("mid.count", count, 0);
        chk("mid.we", we, 0);
        chk("mid.in_ready", mem_if.in_ready, 1);
        chk("mid.fwd1_hit", fwd1_hit, 0);
        chk("mid.fwd2_hit", fwd2_hit, 0);
        cyc(0, 0, 0, 0, 0);
        chk("mid.no_write", we, 0);
        cyc(1, 13, 1300, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("mid.post_we", we, 1);
        chk("mid.post_rw", reg_write, 13);
        chk("mid.post_dw", data_write, 1300);
        check_model("mid");

        // Random traffic against the model.
        for (int i = 0; i < 500; i++) begin
            rs1 = 5'($urandom_range(0, 7));
            rs2 = 5'($urandom_range(0, 7));
            cyc($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)),
                $urandom, $urandom_range(0, 2) == 0,
                $urandom_range(0, 60) == 0);
            check_model($sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
